// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: stall/flush sequencer for load-use, taken-branch and multi-cycle EX hazards
// Ports: clk/rst_n (async active-low); ID/EX hazard inputs; branch_taken, mc_start, cnt_clr;
//        pc_en/ifid_en/idex_en enables, ifid/idex/exmem flushes, busy, stall_cycles/flush_events counters.
module pipeline_stall_controller #(
    parameter int MC_LAT = 4,
    parameter int CNT_W  = 3,
    parameter int PERF_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        IFID_rs,
    input  logic [3:0]        IFID_rt,
    input  logic              IFID_rs_valid,
    input  logic              IFID_rt_valid,
    input  logic [3:0]        IDEX_rd,
    input  logic              IDEX_mem_read,
    input  logic              branch_taken,
    input  logic              mc_start,
    input  logic              cnt_clr,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
);
    typedef enum logic {RUN, MC_WAIT} state_t;
    state_t state;
    logic [CNT_W-1:0] mc_cnt;
    logic run, load_use, br, mc, lu, freeze;
    always_comb begin
        run = state == RUN;
        load_use = IDEX_mem_read && ((IFID_rs_valid && IFID_rs == IDEX_rd) || (IFID_rt_valid && IFID_rt == IDEX_rd));
        br = run && branch_taken;
        mc = run && !branch_taken && mc_start;
        lu = run && !branch_taken && !mc_start && load_use;
        // entry cycle plus every MC_WAIT cycle except the release cycle
        freeze = mc || (!run && mc_cnt > CNT_W'(1));
        pc_en = rst_n && !freeze && !lu;
        ifid_en = rst_n && !freeze && !lu;
        idex_en = rst_n && !freeze;
        ifid_flush = !rst_n || br;
        idex_flush = !rst_n || br || lu;
        exmem_flush = !rst_n || freeze;
        busy = rst_n && !run;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            mc_cnt <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (run) begin
                if (mc) begin
                    state <= MC_WAIT;
                    mc_cnt <= CNT_W'(MC_LAT - 1);
                end
            end else if (mc_cnt > CNT_W'(1)) begin
                mc_cnt <= mc_cnt - 1'b1;
            end else begin
                state <= RUN;
                mc_cnt <= '0;
            end
            if (cnt_clr) begin
                stall_cycles <= '0;
                flush_events <= '0;
            end else begin
                if (!pc_en && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
                if (br && flush_events != '1) flush_events <= flush_events + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb_pipeline_stall_controller: random + directed check of the stall controller against a behavioural model
module tb_pipeline_stall_controller;
    localparam int MC_LAT = 4;
    localparam int MAXP = 65535;
    logic clk = 0, rst_n = 0;
    logic [3:0] IFID_rs = 0, IFID_rt = 0, IDEX_rd = 0;
    logic IFID_rs_valid = 0, IFID_rt_valid = 0, IDEX_mem_read = 0;
    logic branch_taken = 0, mc_start = 0, cnt_clr = 0;
    logic pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, busy;
    logic [15:0] stall_cycles, flush_events;
    int checks = 0, errors = 0;
    int bl = 0, ms = 0, mf = 0;
    logic [6:0] e;
    logic hit, fl;

    pipeline_stall_controller #(.MC_LAT(MC_LAT), .CNT_W(3), .PERF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt),
        .IFID_rs_valid(IFID_rs_valid), .IFID_rt_valid(IFID_rt_valid),
        .IDEX_rd(IDEX_rd), .IDEX_mem_read(IDEX_mem_read), .branch_taken(branch_taken),
        .mc_start(mc_start), .cnt_clr(cnt_clr), .pc_en(pc_en), .ifid_en(ifid_en),
        .idex_en(idex_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .busy(busy), .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: bl counts MC_WAIT cycles still to come; outputs follow the priority rules directly.
    // Vector order: {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, busy}
    always @(negedge clk) begin
        fl = 0;
        if (!rst_n) begin
            e = 7'b000_111_0;
            bl = 0;
            ms = 0;
            mf = 0;
        end else begin
            hit = IDEX_mem_read && ((IFID_rs_valid && IFID_rs == IDEX_rd) || (IFID_rt_valid && IFID_rt == IDEX_rd));
            if (bl > 0) begin
                e = bl > 1 ? 7'b000_001_1 : 7'b111_000_1;
                bl--;
            end else if (branch_taken) begin
                e = 7'b111_110_0;
                fl = 1;
            end else if (mc_start) begin
                e = 7'b000_001_0;
                bl = MC_LAT - 1;
            end else if (hit) e = 7'b001_010_0;
            else e = 7'b111_000_0;
        end
        chk("outs", {25'd0, pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, busy}, {25'd0, e});
        chk("stall_cycles", {16'd0, stall_cycles}, ms);
        chk("flush_events", {16'd0, flush_events}, mf);
        if (rst_n) begin
            if (cnt_clr) begin
                ms = 0;
                mf = 0;
            end else begin
                if (!e[6] && ms < MAXP) ms++;
                if (fl && mf < MAXP) mf++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {IDEX_mem_read, branch_taken, mc_start, cnt_clr, IFID_rs_valid, IFID_rt_valid} = '0;
        {IFID_rs, IFID_rt, IDEX_rd} = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step(1);
        rst_n = 1;
    endtask

    initial begin
        #2;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_flushes", {ifid_flush, idex_flush, exmem_flush}, 3'b111);
        chk("rst_busy", busy, 0);
        step(1);
        rst_n = 1;
        // load-use
        IDEX_mem_read = 1; IDEX_rd = 5; IFID_rs = 5; IFID_rs_valid = 1;
        #2;
        chk("lu_stall", {pc_en, ifid_en, idex_flush}, 3'b001);
        step(1);
        IDEX_mem_read = 0;
        #2;
        chk("lu_release", {pc_en, ifid_en, idex_en}, 3'b111);
        chk("lu_stall_cnt", stall_cycles, 1);
        step(1);
        // false load-use
        IDEX_mem_read = 1; IFID_rt = 5; IFID_rt_valid = 0; IFID_rs = 3;
        #2;
        chk("false_lu_rt", pc_en, 1);
        IDEX_mem_read = 0; IFID_rs = 5;
        #2;
        chk("false_lu_nomr", pc_en, 1);
        step(1);
        // branch beats mc_start and load-use
        do_reset();
        branch_taken = 1; mc_start = 1; IDEX_mem_read = 1; IDEX_rd = 5; IFID_rs = 5; IFID_rs_valid = 1;
        #2;
        chk("br_outs", {ifid_flush, idex_flush, pc_en, exmem_flush}, 4'b1110);
        step(1);
        idle();
        #2;
        chk("br_busy", busy, 0);
        chk("br_flush_cnt", flush_events, 1);
        // multi-cycle op
        do_reset();
        mc_start = 1;
        #2;
        chk("mc_entry", {pc_en, busy}, 2'b00);
        step(1);
        mc_start = 0;
        #2;
        chk("mc_w1", {pc_en, busy}, 2'b01);
        step(1);
        branch_taken = 1;
        #2;
        chk("mc_w2", {pc_en, busy, ifid_flush}, 3'b010);
        step(1);
        #2;
        chk("mc_release", {pc_en, busy, ifid_flush}, 3'b110);
        step(1);
        branch_taken = 0;
        #2;
        chk("mc_done", {busy, stall_cycles}, {1'b0, 16'd3});
        chk("mc_no_flush", flush_events, 0);
        // reset mid-op
        do_reset();
        mc_start = 1;
        step(1);
        mc_start = 0;
        step(1);
        rst_n = 0;
        #1;
        chk("midrst_outs", {busy, ifid_flush, idex_flush, exmem_flush}, 4'b0111);
        chk("midrst_cnt", stall_cycles, 0);
        step(1);
        rst_n = 1;
        #2;
        chk("midrst_run", {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exmem_flush, busy}, 7'b111_000_0);
        // saturation and clear
        do_reset();
        IDEX_mem_read = 1; IDEX_rd = 5; IFID_rs = 5; IFID_rs_valid = 1;
        step(65537);
        #1;
        chk("sat", stall_cycles, 16'hFFFF);
        cnt_clr = 1;
        step(1);
        cnt_clr = 0;
        #1;
        chk("clr", stall_cycles, 0);
        idle();
        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst_n = $urandom_range(0, 99) != 0;
            branch_taken = $urandom_range(0, 7) == 0;
            mc_start = $urandom_range(0, 7) == 0;
            cnt_clr = $urandom_range(0, 49) == 0;
            IDEX_mem_read = $urandom_range(0, 1) == 1;
            IFID_rs_valid = $urandom_range(0, 1) == 1;
            IFID_rt_valid = $urandom_range(0, 1) == 1;
            IFID_rs = 4'($urandom_range(0, 3));
            IFID_rt = 4'($urandom_range(0, 3));
            IDEX_rd = 4'($urandom_range(0, 3));
            step(1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
